// File: rtl/operand_fetch_stage.sv
`default_nettype none
// =============================================================================
// operand_fetch_stage : resolves µop source operands from GPRs and forwarding,
//                       interlocks on pending producers, registers to execute.
// Revision: 1.0
// =============================================================================
module operand_fetch_stage #(
    parameter int REG_W      = 64,
    parameter int REG_ADDR_W = 4,
    parameter int REG_N      = 16,
    parameter int SRC_N      = 3,
    parameter int FWD_N      = 3,
    parameter int MICRO_W    = 8,
    parameter int IMM_W      = 32,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [MICRO_W-1:0]          in_opcode,
    input  logic [IMM_W-1:0]            in_immediate,
    input  logic [ADDR_W-1:0]           in_pc,
    input  logic [SRC_N*REG_ADDR_W-1:0] in_addr,
    input  logic [SRC_N-1:0]            in_use,
    input  logic [REG_N*REG_W-1:0]      gpr_flat,
    input  logic [FWD_N-1:0]            fwd_valid,
    input  logic [FWD_N*REG_ADDR_W-1:0] fwd_addr,
    input  logic [FWD_N*REG_W-1:0]      fwd_data,
    input  logic [FWD_N-1:0]            fwd_ready,
    input  logic                        flush,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [MICRO_W-1:0]          out_opcode,
    output logic [IMM_W-1:0]            out_immediate,
    output logic [ADDR_W-1:0]           out_pc,
    output logic [SRC_N*REG_ADDR_W-1:0] out_addr,
    output logic [SRC_N-1:0]            out_use,
    output logic [SRC_N*REG_W-1:0]      out_val,
    output logic [CNT_W-1:0]            stall_cycles
);

    logic [SRC_N*REG_W-1:0] res_val;
    logic [SRC_N-1:0]       hazard_vec;
    logic                   hazard;
    logic                   accept;

    for (genvar k = 0; k < SRC_N; k++) begin : g_src
        logic [REG_ADDR_W-1:0] addr_k;
        logic [REG_W-1:0]      val_k;
        logic                  hit_k;
        logic                  rdy_k;

        assign addr_k = in_addr[k*REG_ADDR_W +: REG_ADDR_W];

        // Oldest entry is visited first so the youngest match overwrites it.
        always_comb begin
            val_k = '0;
            for (int r = 0; r < REG_N; r++) begin
                if (addr_k == REG_ADDR_W'(r)) begin
                    val_k = gpr_flat[r*REG_W +: REG_W];
                end
            end
            hit_k = 1'b0;
            rdy_k = 1'b1;
            for (int j = FWD_N - 1; j >= 0; j--) begin
                if (fwd_valid[j] && (fwd_addr[j*REG_ADDR_W +: REG_ADDR_W] == addr_k)) begin
                    val_k = fwd_data[j*REG_W +: REG_W];
                    hit_k = 1'b1;
                    rdy_k = fwd_ready[j];
                end
            end
        end

        assign res_val[k*REG_W +: REG_W] = val_k;
        assign hazard_vec[k]             = in_use[k] && hit_k && !rdy_k;
    end

    logic                        out_valid_d,     out_valid_q;
    logic [MICRO_W-1:0]          out_opcode_d,    out_opcode_q;
    logic [IMM_W-1:0]            out_immediate_d, out_immediate_q;
    logic [ADDR_W-1:0]           out_pc_d,        out_pc_q;
    logic [SRC_N*REG_ADDR_W-1:0] out_addr_d,      out_addr_q;
    logic [SRC_N-1:0]            out_use_d,       out_use_q;
    logic [SRC_N*REG_W-1:0]      out_val_d,       out_val_q;
    logic [CNT_W-1:0]            stall_d,         stall_q;

    assign hazard   = in_valid && (|hazard_vec);
    assign in_ready = !rst && !flush && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d     = out_valid_q;
        out_opcode_d    = out_opcode_q;
        out_immediate_d = out_immediate_q;
        out_pc_d        = out_pc_q;
        out_addr_d      = out_addr_q;
        out_use_d       = out_use_q;
        out_val_d       = out_val_q;
        stall_d         = stall_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d     = 1'b1;
            out_opcode_d    = in_opcode;
            out_immediate_d = in_immediate;
            out_pc_d        = in_pc;
            out_addr_d      = in_addr;
            out_use_d       = in_use;
            out_val_d       = res_val;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (hazard && !flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            out_opcode_q    <= '0;
            out_immediate_q <= '0;
            out_pc_q        <= '0;
            out_addr_q      <= '0;
            out_use_q       <= '0;
            out_val_q       <= '0;
            stall_q         <= '0;
        end else begin
            out_valid_q     <= out_valid_d;
            out_opcode_q    <= out_opcode_d;
            out_immediate_q <= out_immediate_d;
            out_pc_q        <= out_pc_d;
            out_addr_q      <= out_addr_d;
            out_use_q       <= out_use_d;
            out_val_q       <= out_val_d;
            stall_q         <= stall_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_opcode    = out_opcode_q;
    assign out_immediate = out_immediate_q;
    assign out_pc        = out_pc_q;
    assign out_addr      = out_addr_q;
    assign out_use       = out_use_q;
    assign out_val       = out_val_q;
    assign stall_cycles  = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
`default_nettype none
// =============================================================================
// tb_operand_fetch_stage : directed checks of operand resolution, interlock,
//                          backpressure, flush, saturation and async reset.
// Revision: 1.0
// =============================================================================
module tb_operand_fetch_stage;

    localparam int REG_W = 64;
    localparam int AW    = 4;
    localparam int REG_N = 16;
    localparam int SRC_N = 3;
    localparam int FWD_N = 3;
    localparam int CNT_W = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [7:0]              in_opcode;
    logic [31:0]             in_immediate;
    logic [31:0]             in_pc;
    logic [SRC_N*AW-1:0]     in_addr;
    logic [SRC_N-1:0]        in_use;
    logic [REG_N*REG_W-1:0]  gpr_flat;
    logic [FWD_N-1:0]        fwd_valid;
    logic [FWD_N*AW-1:0]     fwd_addr;
    logic [FWD_N*REG_W-1:0]  fwd_data;
    logic [FWD_N-1:0]        fwd_ready;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [7:0]              out_opcode;
    logic [31:0]             out_immediate;
    logic [31:0]             out_pc;
    logic [SRC_N*AW-1:0]     out_addr;
    logic [SRC_N-1:0]        out_use;
    logic [SRC_N*REG_W-1:0]  out_val;
    logic [CNT_W-1:0]        stall_cycles;

    logic [REG_W-1:0] gpr [REG_N];
    logic [AW-1:0]    fa  [FWD_N];
    logic [REG_W-1:0] fd  [FWD_N];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < REG_N; r++) gpr_flat[r*REG_W +: REG_W] = gpr[r];
        for (int j = 0; j < FWD_N; j++) begin
            fwd_addr[j*AW +: AW]       = fa[j];
            fwd_data[j*REG_W +: REG_W] = fd[j];
        end
    end

    operand_fetch_stage #(
        .REG_W(REG_W), .REG_ADDR_W(AW), .REG_N(REG_N), .SRC_N(SRC_N), .FWD_N(FWD_N),
        .MICRO_W(8), .IMM_W(32), .ADDR_W(32), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_immediate(in_immediate), .in_pc(in_pc),
        .in_addr(in_addr), .in_use(in_use), .gpr_flat(gpr_flat),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .fwd_ready(fwd_ready), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_immediate(out_immediate), .out_pc(out_pc),
        .out_addr(out_addr), .out_use(out_use), .out_val(out_val),
        .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_uop(input logic [7:0] op, input logic [3:0] a2, input logic [3:0] a1,
                           input logic [3:0] a0, input logic [2:0] use_v);
        in_opcode    = op;
        in_immediate = {24'h0, op};
        in_pc        = 32'h100 + {24'h0, op};
        in_addr      = {a2, a1, a0};
        in_use       = use_v;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        set_uop(8'h00, 4'd0, 4'd0, 4'd0, 3'b000);
        fwd_valid = '0; fwd_ready = '0;
        for (int r = 0; r < REG_N; r++) gpr[r] = 64'h1000 + 64'(r);
        gpr[3] = 64'h11;
        for (int j = 0; j < FWD_N; j++) begin fa[j] = '0; fd[j] = '0; end

        step();
        chk("reset_out_valid", 192'(out_valid), 192'd0);
        chk("reset_in_ready", 192'(in_ready), 192'd0);
        chk("reset_stall", 192'(stall_cycles), 192'd0);
        chk("reset_out_val", out_val, 192'd0);
        rst = 1'b0;

        // plain register reads, back-to-back
        in_valid = 1'b1; out_ready = 1'b1;
        set_uop(8'h21, 4'd3, 4'd3, 4'd3, 3'b111);
        #1 chk("gpr_in_ready", 192'(in_ready), 192'd1);
        step();
        chk("gpr_out_valid", 192'(out_valid), 192'd1);
        chk("gpr_out_val", out_val, {64'h11, 64'h11, 64'h11});
        chk("gpr_out_pc", 192'(out_pc), 192'h121);
        set_uop(8'h22, 4'd4, 4'd2, 4'd1, 3'b111);
        #1 chk("b2b_in_ready", 192'(in_ready), 192'd1);
        step();
        chk("b2b_out_opcode", 192'(out_opcode), 192'h22);
        chk("b2b_out_val", out_val, {64'h1004, 64'h1002, 64'h1001});

        // forwarding priority
        fa[0] = 4'd5; fa[1] = 4'd5; fa[2] = 4'd5;
        fd[0] = 64'hA; fd[1] = 64'hB; fd[2] = 64'hC;
        fwd_valid = 3'b111; fwd_ready = 3'b111;
        set_uop(8'h23, 4'd5, 4'd5, 4'd5, 3'b111);
        step();
        chk("prio_youngest", out_val, {64'hA, 64'hA, 64'hA});
        fwd_valid = 3'b110;
        set_uop(8'h24, 4'd5, 4'd5, 4'd5, 3'b111);
        step();
        chk("prio_second", out_val, {64'hB, 64'hB, 64'hB});
        fwd_valid = 3'b111; fwd_ready = 3'b011;
        set_uop(8'h25, 4'd5, 4'd5, 4'd5, 3'b111);
        #1 chk("shadowed_pending_ready", 192'(in_ready), 192'd1);
        step();
        chk("shadowed_pending_val", out_val, {64'hA, 64'hA, 64'hA});

        // load-use interlock
        fwd_valid = 3'b001; fwd_ready = 3'b000; fa[0] = 4'd2; fd[0] = 64'h55;
        set_uop(8'h30, 4'd1, 4'd1, 4'd2, 3'b001);
        for (int i = 0; i < 3; i++) begin
            #1 chk("loaduse_in_ready", 192'(in_ready), 192'd0);
            step();
        end
        chk("loaduse_drained", 192'(out_valid), 192'd0);
        chk("loaduse_stall3", 192'(stall_cycles), 192'd3);
        fwd_ready = 3'b001; fd[0] = 64'h77;
        #1 chk("loaduse_release", 192'(in_ready), 192'd1);
        step();
        chk("loaduse_val", out_val, {64'h1001, 64'h1001, 64'h77});
        fwd_ready = 3'b000; fd[0] = 64'h55;
        set_uop(8'h31, 4'd1, 4'd1, 4'd2, 3'b110);
        #1 chk("unused_no_hazard", 192'(in_ready), 192'd1);
        step();
        chk("unused_val", out_val, {64'h1001, 64'h1001, 64'h55});
        chk("unused_stall", 192'(stall_cycles), 192'd3);

        // backpressure
        fwd_valid = 3'b000;
        set_uop(8'h44, 4'd8, 4'd7, 4'd6, 3'b111);
        step();
        out_ready = 1'b0;
        set_uop(8'h45, 4'd9, 4'd9, 4'd9, 3'b111);
        gpr[6] = 64'hF6; gpr[7] = 64'hF7; gpr[8] = 64'hF8;
        fwd_valid = 3'b001; fwd_ready = 3'b001; fa[0] = 4'd6; fd[0] = 64'hDEAD;
        for (int i = 0; i < 4; i++) begin
            #1 chk("bp_in_ready", 192'(in_ready), 192'd0);
            step();
            chk("bp_opcode", 192'(out_opcode), 192'h44);
            chk("bp_val", out_val, {64'h1008, 64'h1007, 64'h1006});
        end
        out_ready = 1'b1;
        #1 chk("bp_drain_ready", 192'(in_ready), 192'd1);
        step();
        chk("bp_next_opcode", 192'(out_opcode), 192'h45);
        chk("bp_next_valid", 192'(out_valid), 192'd1);

        // flush with valid output and valid input
        fwd_valid = 3'b000;
        set_uop(8'h46, 4'd1, 4'd1, 4'd1, 3'b111);
        flush = 1'b1;
        #1 chk("flush_in_ready", 192'(in_ready), 192'd0);
        step();
        chk("flush_out_valid", 192'(out_valid), 192'd0);
        chk("flush_payload_kept", 192'(out_opcode), 192'h45);
        flush = 1'b0;
        step();
        chk("flush_uop_kept", 192'(out_opcode), 192'h46);
        chk("flush_uop_valid", 192'(out_valid), 192'd1);

        // counter saturation
        fwd_valid = 3'b001; fwd_ready = 3'b000; fa[0] = 4'd2;
        set_uop(8'h50, 4'd1, 4'd1, 4'd2, 3'b001);
        for (int i = 0; i < 10; i++) step();
        chk("stall_saturate", 192'(stall_cycles), 192'd7);

        // async reset mid-stall
        #3 rst = 1'b1;
        #1;
        chk("arst_stall", 192'(stall_cycles), 192'd0);
        chk("arst_opcode", 192'(out_opcode), 192'd0);
        chk("arst_out_valid", 192'(out_valid), 192'd0);
        chk("arst_in_ready", 192'(in_ready), 192'd0);
        step();
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
